shift_add_multiplier: RTL and testbench
=======================================

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter N, default 8: operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request pulse; operands and mode sampled when accepted.
REQ-005 sgn  input  1  mode: 0 = unsigned, 1 = two's-complement signed; sampled with operands.
REQ-006 inA  input  N  multiplicand.
REQ-007 inB  input  N  multiplier.
REQ-008 out  output  2N  registered product.
REQ-009 busy  output  1  high while a multiplication is in progress.
REQ-010 done  output  1  one-cycle pulse marking a new valid out.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-012 start SHALL be accepted only in IDLE or DONE; a rising edge with start=1 in either state loads inA, inB and sgn, clears the accumulator and bit counter, and enters CALC.
REQ-013 start in CALC SHALL be ignored with no effect on the running operation.
REQ-014 In CALC, each edge SHALL perform one shift-add step on one multiplier bit, LSB first, and increment the bit counter.
REQ-015 After exactly N CALC edges, the FSM SHALL enter DONE and load out with the final product on that same edge.
REQ-016 Latency SHALL be fixed at N edges from the accepting edge to out/done valid, independent of operand values, zero operands included.
REQ-017 done SHALL be high only in DONE, which lasts exactly one cycle; the next state is IDLE, or CALC if start=1.
REQ-018 busy SHALL be high exactly in CALC.
REQ-019 out SHALL hold its value from DONE until the next DONE; it changes on no other edge except reset.
REQ-020 Unsigned mode: out SHALL equal inA*inB as an unsigned 2N-bit value, with no overflow possible.
REQ-021 Signed mode: operands SHALL be converted to magnitudes at load, the unsigned product formed, and the result negated in 2N bits if exactly one operand was negative.
REQ-022 Signed mode SHALL handle the most-negative operand correctly, e.g. N=8: -128*-128 = 16384 and -128*127 = -16256.
REQ-023 Input changes while busy SHALL NOT affect the result; only values captured at acceptance are used.

Reset
REQ-024 When rst=1 on an edge, the FSM SHALL go to IDLE, and out, accumulator, counter and captured operands SHALL clear to 0.
REQ-025 During reset, busy=0 and done=0.
REQ-026 rst mid-operation (CALC or DONE) SHALL abort the operation with no done pulse.
REQ-027 rst SHALL take priority over start on the same edge.

Structure
REQ-028 A shared package/header mult_pkg SHALL hold the state encodings (IDLE, CALC, DONE) and the default width constant.
REQ-029 The design SHALL split into a controller sub-module shift_add_multiplier_ctrl (FSM, bit counter, busy/done, load/shift enables) and datapath logic in the top module.
REQ-030 The bit counter width SHALL be clog2(N)+1.

Verification
REQ-031 N=8 unsigned: 5 x 10 -> out=50, done pulses exactly 8 edges after the accepting edge, busy high for 8 cycles.
REQ-032 N=8 unsigned: 48 x 55 -> 2640; 255 x 255 -> 65025; 0 x 200 -> 0 with identical 8-cycle latency.
REQ-033 N=8 signed: -7 x 9 -> 16'hFFC1 (-63); -128 x -128 -> 16384; -128 x 127 -> -16256.
REQ-034 Start pulses and changes to inA/inB during CALC (e.g. 3 x 3 -> 9 while inputs toggle) -> ignored, out=9, single done.
REQ-035 Back-to-back: start asserted during DONE with new operands (6 x 7 after 5 x 10) -> out=50 then 42, no idle gap.
REQ-036 rst asserted at CALC cycle 4 -> no done, out=0, busy=0; a following 12 x 12 (N=16 build also run) -> 144.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier.
//   DEFAULT_N : default operand width in bits
//   state_e   : controller state encoding (IDLE, CALC, DONE)
package mult_pkg;

    localparam int unsigned DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/shift_add_multiplier_ctrl.sv
// Controller for the shift-add multiplier: FSM, bit counter and datapath enables.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   start    : request pulse, honoured in IDLE or DONE only
//   busy     : high exactly in CALC
//   done     : high exactly in DONE (one cycle)
//   load     : capture operands and clear the accumulator on this edge
//   step     : perform one shift-add step on this edge
//   last     : this edge performs the final step; the product is registered
module shift_add_multiplier_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic load,
    output logic step,
    output logic last
);

    localparam int unsigned CW = $clog2(N) + 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q;

    // State register and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                cnt_q <= '0;
            end else if (step) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (last)  state_d = DONE;
            DONE:    state_d = start ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs; gated by rst so busy/done read low while reset is asserted
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        load = 1'b0;
        step = 1'b0;
        last = 1'b0;
        if (!rst) begin
            busy = (state_q == CALC);
            done = (state_q == DONE);
            load = start && (state_q == IDLE || state_q == DONE);
            step = (state_q == CALC);
            last = step && (cnt_q == CW'(N - 1));
        end
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier, unsigned or two's-complement signed.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   start     : request pulse; inA, inB, sgn captured when accepted
//   sgn       : 0 = unsigned, 1 = signed
//   inA, inB  : N-bit multiplicand and multiplier
//   out       : registered 2N-bit product, held until the next completion
//   busy      : high while a multiplication is running
//   done      : one-cycle pulse when out takes a new value
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           sgn,
    input  logic [N-1:0]   inA,
    input  logic [N-1:0]   inB,
    output logic [2*N-1:0] out,
    output logic           busy,
    output logic           done
);

    logic load, step, last;

    logic [2*N-1:0] a_q, acc_q, out_q, acc_nxt, prod;
    logic [N-1:0]   b_q, a_mag, b_mag;
    logic           neg_q;

    shift_add_multiplier_ctrl #(
        .N(N)
    ) u_ctrl (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .busy (busy),
        .done (done),
        .load (load),
        .step (step),
        .last (last)
    );

    // Magnitudes at load; the most-negative value maps to 2^(N-1), which
    // still fits as an unsigned N-bit number.
    always_comb begin
        a_mag = (sgn && inA[N-1]) ? (~inA + 1'b1) : inA;
        b_mag = (sgn && inB[N-1]) ? (~inB + 1'b1) : inB;
    end

    always_comb begin
        acc_nxt = b_q[0] ? (acc_q + a_q) : acc_q;
        prod    = neg_q ? (~acc_nxt + 1'b1) : acc_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            neg_q <= 1'b0;
            acc_q <= '0;
            out_q <= '0;
        end else if (load) begin
            a_q   <= {{N{1'b0}}, a_mag};
            b_q   <= b_mag;
            neg_q <= sgn && (inA[N-1] ^ inB[N-1]);
            acc_q <= '0;
        end else if (step) begin
            acc_q <= acc_nxt;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            if (last) begin
                out_q <= prod;
            end
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

    localparam int unsigned N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           sgn;
    logic [N-1:0]   inA, inB;
    logic [2*N-1:0] out;
    logic           busy, done;

    int checks = 0;
    int passes = 0;

    logic [2*N-1:0] exp_prod;
    logic [2*N-1:0] last_out;

    shift_add_multiplier #(
        .N(N)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sgn  (sgn),
        .inA  (inA),
        .inB  (inB),
        .out  (out),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Reference: mathematical product reduced to 2N bits
    function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic s);
        longint pa, pb, p;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'(a);
            pb = longint'(b);
        end
        p = pa * pb;
        return p[2*N-1:0];
    endfunction

    // Present a request at the current negedge; it is accepted on the next posedge
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        start    = 1'b1;
        inA      = a;
        inB      = b;
        sgn      = s;
        exp_prod = model(a, b, s);
    endtask

    // Walk through the N CALC cycles, optionally scrambling inputs, then check DONE
    task automatic finish_op(input string tag, input bit scramble);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " no-done"}, 32'(done), 32'd0);
            check({tag, " out-held"}, 32'(out), 32'(last_out));
            if (scramble) begin
                start = 1'($urandom);
                inA   = N'($urandom);
                inB   = N'($urandom);
                sgn   = 1'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy-off"}, 32'(busy), 32'd0);
        check({tag, " out"}, 32'(out), 32'(exp_prod));
        last_out = exp_prod;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, " done-drop"}, 32'(done), 32'd0);
        check({tag, " idle-busy"}, 32'(busy), 32'd0);
        check({tag, " out-hold"}, 32'(out), 32'(last_out));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b1;
        sgn      = 1'b0;
        inA      = '0;
        inB      = '0;
        last_out = '0;
        exp_prod = '0;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        check("reset out", 32'(out), 32'd0);
        check("reset busy2", 32'(busy), 32'd0);
        check("reset done2", 32'(done), 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        // Directed unsigned
        issue(8'd5, 8'd10, 1'b0);    finish_op("u5x10", 1'b0);    idle_check("u5x10");
        issue(8'd48, 8'd55, 1'b0);   finish_op("u48x55", 1'b0);   idle_check("u48x55");
        issue(8'd255, 8'd255, 1'b0); finish_op("u255x255", 1'b0); idle_check("u255x255");
        issue(8'd0, 8'd200, 1'b0);   finish_op("u0x200", 1'b0);   idle_check("u0x200");

        // Directed signed, including the most-negative operand
        issue(8'hF9, 8'd9, 1'b1);    finish_op("s-7x9", 1'b0);    idle_check("s-7x9");
        check("s-7x9 literal", 32'(out), 32'h0000_FFC1);
        issue(8'h80, 8'h80, 1'b1);   finish_op("s-128x-128", 1'b0);
        check("s-128x-128 literal", 32'(out), 32'd16384);
        idle_check("s-128x-128");
        issue(8'h80, 8'd127, 1'b1);  finish_op("s-128x127", 1'b0);
        check("s-128x127 literal", 32'(out), 32'h0000_C080);
        idle_check("s-128x127");

        // Inputs and start toggling during CALC must be ignored
        issue(8'd3, 8'd3, 1'b0);     finish_op("u3x3 scramble", 1'b1);
        idle_check("u3x3 scramble");

        // Back-to-back: new request presented during DONE
        issue(8'd5, 8'd10, 1'b0);    finish_op("b2b first", 1'b0);
        issue(8'd6, 8'd7, 1'b0);     finish_op("b2b second", 1'b0);
        idle_check("b2b second");

        // Reset in the middle of CALC
        issue(8'd100, 8'd100, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort busy-before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort busy-in-reset", 32'(busy), 32'd0);
        check("abort done-in-reset", 32'(done), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        last_out = '0;
        check("abort out", 32'(out), 32'd0);
        for (int i = 0; i < int'(N) + 2; i++) begin
            check("abort no-done", 32'(done), 32'd0);
            check("abort busy", 32'(busy), 32'd0);
            @(negedge clk);
        end
        issue(8'd12, 8'd12, 1'b0);   finish_op("u12x12", 1'b0);   idle_check("u12x12");

        // Reset takes priority over start on the same edge
        rst = 1'b1;
        issue(8'd9, 8'd9, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        last_out = '0;
        check("rst-prio busy", 32'(busy), 32'd0);
        check("rst-prio out", 32'(out), 32'd0);
        @(negedge clk);

        // Randomized operands in both modes
        for (int k = 0; k < 40; k++) begin
            issue(N'($urandom), N'($urandom), 1'($urandom));
            finish_op("random", 1'(k % 2));
            if (k % 3 == 0) begin
                idle_check("random");
            end
        end
        @(negedge clk);
        start = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
